wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//  Write-side master for the 32x32 register file; drives its write port (i_rd_wren/addr/data).
//  Merges two sources: in-order pipeline writeback (single-cycle ALU/LSU) and a long-latency unit
//  (LU, e.g. iterative mul/div). Tracks pending LU destinations in a scoreboard.
//  Raises the decode stall on RAW/WAW hazards against those destinations.
// PARAMETERS
//  DATA_W          32  register data width
//  ADDR_W          5   register address width (2**ADDR_W registers, x0 hardwired zero)
//  MAX_OUTSTANDING 4   max LU ops in flight; CNT_W = $clog2(MAX_OUTSTANDING+1)
// PORTS
//  i_clk          in   1       clock, all state on rising edge
//  i_rst_n        in   1       asynchronous active-low reset
//  i_pipe_wren    in   1       pipeline writeback valid (no backpressure, always accepted)
//  i_pipe_rd_addr in   ADDR_W  pipeline destination
//  i_pipe_rd_data in   DATA_W  pipeline result
//  i_lu_issue     in   1       LU op issued this cycle (qualified by o_issue_ok upstream)
//  i_lu_issue_rd  in   ADDR_W  destination of issued LU op
//  i_lu_valid     in   1       LU result valid
//  i_lu_rd_addr   in   ADDR_W  LU result destination
//  i_lu_rd_data   in   DATA_W  LU result data
//  o_lu_ready     out  1       LU result accepted when i_lu_valid & o_lu_ready
//  i_rs1_addr     in   ADDR_W  decode source 1
//  i_rs2_addr     in   ADDR_W  decode source 2
//  i_dec_rd_addr  in   ADDR_W  decode destination
//  o_stall        out  1       decode hazard stall
//  o_issue_ok     out  1       outstanding count < MAX_OUTSTANDING
//  o_rd_wren      out  1       to regfile write enable
//  o_rd_addr      out  ADDR_W  to regfile write address
//  o_rd_data      out  DATA_W  to regfile write data
//  o_err          out  1       sticky protocol error
// BEHAVIOUR
//  Reset: scoreboard=0, count=0, buffer empty, o_err=0 -> o_lu_ready=1, o_issue_ok=1, o_stall=0,
//   o_rd_wren=0. Reset mid-operation drops buffered result and all pending state.
//  Write mux (combinational, 0-cycle; regfile commits on next edge):
//   priority pipe > buffered LU > accepted fresh LU. o_rd_wren=0 when selected addr==0.
//  Holding buffer (1 entry): o_lu_ready = ~buf_valid. A fresh LU result accepted while the pipe writes
//   is captured; otherwise it passes straight through. The buffer drains on the first cycle with
//   i_pipe_wren=0; o_lu_ready rises the cycle after the drain. Worst-case LU latency: 1 + pipe-busy cycles.
//  LU commit = LU result (buffered or fresh) selected by the mux, including rd==0 (no write, still commits).
//  Scoreboard busy[31:0]:
//   - set on i_lu_issue for i_lu_issue_rd!=0;
//   - clear on LU commit for its addr;
//   - set and clear of the same reg in one cycle -> set wins; busy[0] is always 0.
//  Count:
//   - +1 on i_lu_issue; -1 on LU commit; both in one cycle -> unchanged;
//   - o_issue_ok = count<MAX_OUTSTANDING.
//  o_stall = (busy[rs1]&rs1!=0) | (busy[rs2]&rs2!=0) | (busy[dec_rd]&dec_rd!=0); combinational from
//   registered busy (stall releases the cycle after the commit edge, and the regfile already holds data).
//  o_err set (sticky until reset) on any of:
//   - i_lu_issue with count==MAX (issue ignored);
//   - LU commit with count==0 (count held at 0);
//   - pipe write to a busy register (write still performed);
//   - i_lu_valid for an addr whose busy bit is 0.
// STRUCTURE
//  Package wb_pkg: DATA_W/ADDR_W defaults; typedef wb_req_t {logic wren; logic [ADDR_W-1:0] addr;
//   logic [DATA_W-1:0] data;}; enum wb_src_e {SRC_NONE, SRC_PIPE, SRC_BUF, SRC_LU}.
//  Sub-module wb_scoreboard: busy vector + outstanding counter + stall/issue_ok logic.
//  Top holds the buffer, the write mux and o_err.
// TESTING
//  1 Reset: i_rst_n=0 with i_lu_valid=1 -> o_rd_wren=0, o_lu_ready=1, o_stall=0, o_err=0.
//  2 Issue rd=5, then rs1=5 at decode -> o_stall=1; LU returns 0xDEADBEEF to x5 -> o_rd_wren=1,
//    addr=5, data=0xDEADBEEF the same cycle; o_stall=0 the next cycle.
//  3 LU valid (x7, 0x11) while pipe writes (x3, 0x22) -> regfile gets x3=0x22, o_lu_ready=0;
//    next idle pipe cycle -> x7=0x11, o_lu_ready=1 the following cycle.
//  4 Issue 4 ops -> o_issue_ok=0; 5th issue -> o_err=1, count stays 4; one commit plus one issue in
//    the same cycle -> count stays 4.
//  5 Issue to x0 -> busy unchanged, count+1; LU result to x0 -> o_rd_wren=0, count-1.
//  6 Pipe write to busy x9 -> o_err=1; reset mid-buffer -> buffer lost, no write after reset.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and default sizes for the register-file write-side arbiter.
//   DATA_W / ADDR_W / MAX_OUTSTANDING : default widths and LU in-flight limit
//   wb_req_t                          : one register-file write (enable, address, data)
//   wb_src_e                          : which source owns the write port this cycle
package wb_pkg;

  localparam int DATA_W          = 32;
  localparam int ADDR_W          = 5;
  localparam int MAX_OUTSTANDING = 4;

  typedef struct packed {
    logic              wren;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_PIPE = 2'd1,
    SRC_BUF  = 2'd2,
    SRC_LU   = 2'd3
  } wb_src_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-destination tracker for long-latency (LU) operations.
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   i_issue, i_issue_rd   : LU op issued and its destination
//   i_commit, i_commit_rd : LU result committed through the write mux, and its address
//   i_rs1_addr/i_rs2_addr/i_dec_rd_addr : decode operands checked for hazards
//   o_busy                : registered per-register pending bits (bit 0 always 0)
//   o_stall               : decode hazard against a pending destination
//   o_issue_ok            : outstanding count below the limit
//   o_overflow            : issue attempted with no free slot (issue dropped)
//   o_underflow           : commit seen with nothing outstanding (count held)
module wb_scoreboard #(
  parameter int ADDR_W          = 5,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_issue,
  input  logic [ADDR_W-1:0]      i_issue_rd,
  input  logic                   i_commit,
  input  logic [ADDR_W-1:0]      i_commit_rd,
  input  logic [ADDR_W-1:0]      i_rs1_addr,
  input  logic [ADDR_W-1:0]      i_rs2_addr,
  input  logic [ADDR_W-1:0]      i_dec_rd_addr,
  output logic [(2**ADDR_W)-1:0] o_busy,
  output logic                   o_stall,
  output logic                   o_issue_ok,
  output logic                   o_overflow,
  output logic                   o_underflow
);

  localparam int NREG  = 2**ADDR_W;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [NREG-1:0]  busy_q, busy_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             cnt_full, cnt_empty;
  logic             issue_acc, commit_acc;

  assign cnt_full  = (cnt_q == CNT_W'(MAX_OUTSTANDING));
  assign cnt_empty = (cnt_q == '0);

  // A commit in the same cycle frees the slot the new issue takes, so a
  // full counter only rejects an issue when nothing retires alongside it.
  assign issue_acc   = i_issue & (~cnt_full | i_commit);
  assign commit_acc  = i_commit & ~cnt_empty;
  assign o_overflow  = i_issue & cnt_full & ~i_commit;
  assign o_underflow = i_commit & cnt_empty;

  always_comb begin
    busy_nxt = busy_q;
    if (i_commit) busy_nxt[i_commit_rd] = 1'b0;
    // Set is applied after clear so a same-cycle set/clear of one register leaves it busy.
    if (issue_acc && (i_issue_rd != '0)) busy_nxt[i_issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    cnt_nxt = cnt_q;
    case ({issue_acc, commit_acc})
      2'b10:   cnt_nxt = cnt_q + 1'b1;
      2'b01:   cnt_nxt = cnt_q - 1'b1;
      default: cnt_nxt = cnt_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_nxt;
      cnt_q  <= cnt_nxt;
    end
  end

  assign o_busy     = busy_q;
  assign o_issue_ok = ~cnt_full;
  assign o_stall    = (busy_q[i_rs1_addr]    & (i_rs1_addr    != '0)) |
                      (busy_q[i_rs2_addr]    & (i_rs2_addr    != '0)) |
                      (busy_q[i_dec_rd_addr] & (i_dec_rd_addr != '0));

endmodule

// File: rtl/wb_arbiter.sv
// Write-side master for the register file. Merges the in-order pipeline
// writeback with results from a long-latency unit (LU), tracks pending LU
// destinations and raises the decode stall on hazards.
//   i_clk, i_rst_n                          : clock, asynchronous active-low reset
//   i_pipe_wren/_rd_addr/_rd_data           : pipeline writeback, always accepted
//   i_lu_issue, i_lu_issue_rd               : LU op issued this cycle
//   i_lu_valid/_rd_addr/_rd_data, o_lu_ready: LU result channel
//   i_rs1_addr, i_rs2_addr, i_dec_rd_addr   : decode operands
//   o_stall, o_issue_ok                     : decode stall, LU issue permitted
//   o_rd_wren, o_rd_addr, o_rd_data         : register-file write port
//   o_err                                   : sticky protocol error
//
// LU result handshake: a result transfers on a rising edge where
// i_lu_valid & o_lu_ready are both 1. o_lu_ready never depends on i_lu_valid;
// the LU must hold valid/addr/data stable until the transfer happens.
import wb_pkg::*;

module wb_arbiter #(
  parameter int DATA_W          = wb_pkg::DATA_W,
  parameter int ADDR_W          = wb_pkg::ADDR_W,
  parameter int MAX_OUTSTANDING = wb_pkg::MAX_OUTSTANDING
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_pipe_wren,
  input  logic [ADDR_W-1:0] i_pipe_rd_addr,
  input  logic [DATA_W-1:0] i_pipe_rd_data,
  input  logic              i_lu_issue,
  input  logic [ADDR_W-1:0] i_lu_issue_rd,
  input  logic              i_lu_valid,
  input  logic [ADDR_W-1:0] i_lu_rd_addr,
  input  logic [DATA_W-1:0] i_lu_rd_data,
  output logic              o_lu_ready,
  input  logic [ADDR_W-1:0] i_rs1_addr,
  input  logic [ADDR_W-1:0] i_rs2_addr,
  input  logic [ADDR_W-1:0] i_dec_rd_addr,
  output logic              o_stall,
  output logic              o_issue_ok,
  output logic              o_rd_wren,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_err
);

  wb_req_t                 buf_q;    // buf_q.wren doubles as the buffer-valid flag
  wb_req_t                 wr;
  wb_src_e                 src;
  logic                    lu_accept, lu_capture, lu_commit;
  logic [(2**ADDR_W)-1:0]  busy;
  logic                    overflow, underflow;
  logic                    err_pipe_busy, err_lu_idle;

  assign o_lu_ready = ~buf_q.wren;
  // Nothing is accepted while reset is asserted, so a held LU valid cannot leak a write.
  assign lu_accept  = i_rst_n & i_lu_valid & ~buf_q.wren;
  assign lu_capture = lu_accept & i_pipe_wren;

  always_comb begin
    src = SRC_NONE;
    if (i_rst_n) begin
      if (i_pipe_wren)     src = SRC_PIPE;
      else if (buf_q.wren) src = SRC_BUF;
      else if (lu_accept)  src = SRC_LU;
    end
  end

  always_comb begin
    wr = '0;
    case (src)
      SRC_PIPE: begin wr.addr = i_pipe_rd_addr; wr.data = i_pipe_rd_data; end
      SRC_BUF:  begin wr.addr = buf_q.addr;     wr.data = buf_q.data;     end
      SRC_LU:   begin wr.addr = i_lu_rd_addr;   wr.data = i_lu_rd_data;   end
      default:  wr = '0;
    endcase
    // x0 is hardwired: the slot is still consumed, but no write is issued.
    wr.wren = (src != SRC_NONE) && (wr.addr != '0);
  end

  assign lu_commit = (src == SRC_BUF) || (src == SRC_LU);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      buf_q <= '0;
    end else if (lu_capture) begin
      buf_q.wren <= 1'b1;
      buf_q.addr <= i_lu_rd_addr;
      buf_q.data <= i_lu_rd_data;
    end else if (src == SRC_BUF) begin
      buf_q.wren <= 1'b0;
    end
  end

  wb_scoreboard #(
    .ADDR_W          (ADDR_W),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_scoreboard (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_issue       (i_lu_issue),
    .i_issue_rd    (i_lu_issue_rd),
    .i_commit      (lu_commit),
    .i_commit_rd   (wr.addr),
    .i_rs1_addr    (i_rs1_addr),
    .i_rs2_addr    (i_rs2_addr),
    .i_dec_rd_addr (i_dec_rd_addr),
    .o_busy        (busy),
    .o_stall       (o_stall),
    .o_issue_ok    (o_issue_ok),
    .o_overflow    (overflow),
    .o_underflow   (underflow)
  );

  assign err_pipe_busy = i_pipe_wren & busy[i_pipe_rd_addr];
  assign err_lu_idle   = i_lu_valid & ~busy[i_lu_rd_addr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_err <= 1'b0;
    else if (overflow | underflow | err_pipe_busy | err_lu_idle) o_err <= 1'b1;
  end

  assign o_rd_wren = wr.wren;
  assign o_rd_addr = wr.addr;
  assign o_rd_data = wr.data;

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_wren;
  logic [4:0]  pipe_rd_addr;
  logic [31:0] pipe_rd_data;
  logic        lu_issue;
  logic [4:0]  lu_issue_rd;
  logic        lu_valid;
  logic [4:0]  lu_rd_addr;
  logic [31:0] lu_rd_data;
  logic        lu_ready;
  logic [4:0]  rs1_addr, rs2_addr, dec_rd_addr;
  logic        stall, issue_ok, rd_wren, err;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_pipe_wren    (pipe_wren),
    .i_pipe_rd_addr (pipe_rd_addr),
    .i_pipe_rd_data (pipe_rd_data),
    .i_lu_issue     (lu_issue),
    .i_lu_issue_rd  (lu_issue_rd),
    .i_lu_valid     (lu_valid),
    .i_lu_rd_addr   (lu_rd_addr),
    .i_lu_rd_data   (lu_rd_data),
    .o_lu_ready     (lu_ready),
    .i_rs1_addr     (rs1_addr),
    .i_rs2_addr     (rs2_addr),
    .i_dec_rd_addr  (dec_rd_addr),
    .o_stall        (stall),
    .o_issue_ok     (issue_ok),
    .o_rd_wren      (rd_wren),
    .o_rd_addr      (rd_addr),
    .o_rd_data      (rd_data),
    .o_err          (err)
  );

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    pipe_wren = 0; pipe_rd_addr = 0; pipe_rd_data = 0;
    lu_issue = 0; lu_issue_rd = 0;
    lu_valid = 0; lu_rd_addr = 0; lu_rd_data = 0;
    rs1_addr = 0; rs2_addr = 0; dec_rd_addr = 0;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic adv();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    adv(); adv();
    rst_n = 1;
    adv();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst_n = 1; #2;
    rst_n = 0;
    lu_valid = 1; lu_rd_addr = 5'd5; lu_rd_data = 32'h1234_5678;
    @(negedge clk);
    checks++; if (rd_wren !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b exp 0", rd_wren); end
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", lu_ready); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b exp 0", stall); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", err); end
    checks++; if (issue_ok !== 1'b1) begin errors++; $display("FAIL reset_issue_ok: got %b exp 1", issue_ok); end
    adv();
    idle_inputs();
    adv();
    rst_n = 1;
    adv();
  endtask

  task automatic test_raw_stall();
    lu_issue = 1; lu_issue_rd = 5'd5;
    adv();
    lu_issue = 0; rs1_addr = 5'd5;
    @(negedge clk);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_stall_set: got %b exp 1", stall); end
    adv();
    lu_valid = 1; lu_rd_addr = 5'd5; lu_rd_data = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if ({rd_wren, rd_addr, rd_data} !== {1'b1, 5'd5, 32'hDEAD_BEEF})
      begin errors++; $display("FAIL raw_lu_write: got %b/%0d/%h exp 1/5/deadbeef", rd_wren, rd_addr, rd_data); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_stall_commit_cycle: got %b exp 1", stall); end
    adv();
    lu_valid = 0;
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_stall_release: got %b exp 0", stall); end
    checks++; if (rd_wren !== 1'b0) begin errors++; $display("FAIL raw_idle_wren: got %b exp 0", rd_wren); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL raw_err: got %b exp 0", err); end
    idle_inputs();
  endtask

  task automatic test_buffer();
    lu_issue = 1; lu_issue_rd = 5'd7;
    adv();
    lu_issue = 0;
    lu_valid = 1; lu_rd_addr = 5'd7; lu_rd_data = 32'h11;
    pipe_wren = 1; pipe_rd_addr = 5'd3; pipe_rd_data = 32'h22;
    @(negedge clk);
    checks++; if ({rd_wren, rd_addr, rd_data} !== {1'b1, 5'd3, 32'h22})
      begin errors++; $display("FAIL buf_pipe_first: got %b/%0d/%h exp 1/3/22", rd_wren, rd_addr, rd_data); end
    adv();
    lu_valid = 0;
    pipe_rd_addr = 5'd4; pipe_rd_data = 32'h33;
    @(negedge clk);
    checks++; if (lu_ready !== 1'b0) begin errors++; $display("FAIL buf_ready_low: got %b exp 0", lu_ready); end
    checks++; if ({rd_wren, rd_addr, rd_data} !== {1'b1, 5'd4, 32'h33})
      begin errors++; $display("FAIL buf_pipe_second: got %b/%0d/%h exp 1/4/33", rd_wren, rd_addr, rd_data); end
    adv();
    pipe_wren = 0;
    @(negedge clk);
    checks++; if ({rd_wren, rd_addr, rd_data} !== {1'b1, 5'd7, 32'h11})
      begin errors++; $display("FAIL buf_drain: got %b/%0d/%h exp 1/7/11", rd_wren, rd_addr, rd_data); end
    checks++; if (lu_ready !== 1'b0) begin errors++; $display("FAIL buf_ready_drain_cycle: got %b exp 0", lu_ready); end
    adv();
    rs1_addr = 5'd7;
    @(negedge clk);
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL buf_ready_back: got %b exp 1", lu_ready); end
    checks++; if (rd_wren !== 1'b0) begin errors++; $display("FAIL buf_no_rewrite: got %b exp 0", rd_wren); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL buf_x7_clear: got %b exp 0", stall); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL buf_err: got %b exp 0", err); end
    idle_inputs();
  endtask

  task automatic test_outstanding();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      lu_issue = 1; lu_issue_rd = 5'(10 + i);
      adv();
    end
    lu_issue = 0;
    @(negedge clk);
    checks++; if (issue_ok !== 1'b0) begin errors++; $display("FAIL cnt_full: got %b exp 0", issue_ok); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL cnt_full_err: got %b exp 0", err); end
    adv();
    lu_issue = 1; lu_issue_rd = 5'd14;
    adv();
    lu_issue = 0; rs1_addr = 5'd14;
    @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL cnt_overflow_err: got %b exp 1", err); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL cnt_overflow_ignored: got %b exp 0", stall); end
    adv();
    lu_valid = 1; lu_rd_addr = 5'd10; lu_rd_data = 32'hA0;
    lu_issue = 1; lu_issue_rd = 5'd15;
    @(negedge clk);
    checks++; if ({rd_wren, rd_addr} !== {1'b1, 5'd10})
      begin errors++; $display("FAIL cnt_commit_write: got %b/%0d exp 1/10", rd_wren, rd_addr); end
    adv();
    lu_valid = 0; lu_issue = 0; rs1_addr = 5'd15;
    @(negedge clk);
    checks++; if (issue_ok !== 1'b0) begin errors++; $display("FAIL cnt_hold_4: got %b exp 0", issue_ok); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL cnt_x15_busy: got %b exp 1", stall); end
    adv();
    lu_valid = 1; lu_rd_addr = 5'd11; lu_rd_data = 32'hB0;
    adv();
    lu_valid = 0;
    @(negedge clk);
    checks++; if (issue_ok !== 1'b1) begin errors++; $display("FAIL cnt_dec_to_3: got %b exp 1", issue_ok); end
    idle_inputs();
  endtask

  task automatic test_x0();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      lu_issue = 1; lu_issue_rd = 5'd0;
      adv();
    end
    lu_issue = 0;
    @(negedge clk);
    checks++; if (issue_ok !== 1'b0) begin errors++; $display("FAIL x0_count: got %b exp 0", issue_ok); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL x0_no_busy: got %b exp 0", stall); end
    adv();
    lu_valid = 1; lu_rd_addr = 5'd0; lu_rd_data = 32'h55;
    @(negedge clk);
    checks++; if (rd_wren !== 1'b0) begin errors++; $display("FAIL x0_no_write: got %b exp 0", rd_wren); end
    adv();
    lu_valid = 0;
    @(negedge clk);
    checks++; if (issue_ok !== 1'b1) begin errors++; $display("FAIL x0_commit_dec: got %b exp 1", issue_ok); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL x0_lu_idle_err: got %b exp 1", err); end
    idle_inputs();
  endtask

  task automatic test_err_and_reset();
    do_reset();
    lu_issue = 1; lu_issue_rd = 5'd9;
    adv();
    lu_issue = 0;
    pipe_wren = 1; pipe_rd_addr = 5'd9; pipe_rd_data = 32'h99;
    @(negedge clk);
    checks++; if ({rd_wren, rd_addr, rd_data} !== {1'b1, 5'd9, 32'h99})
      begin errors++; $display("FAIL busy_pipe_write: got %b/%0d/%h exp 1/9/99", rd_wren, rd_addr, rd_data); end
    adv();
    pipe_wren = 0;
    @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL busy_pipe_err: got %b exp 1", err); end
    lu_issue = 1; lu_issue_rd = 5'd8;
    adv();
    lu_issue = 0;
    lu_valid = 1; lu_rd_addr = 5'd8; lu_rd_data = 32'hBB;
    pipe_wren = 1; pipe_rd_addr = 5'd1; pipe_rd_data = 32'hAA;
    adv();
    lu_valid = 0; pipe_rd_addr = 5'd2;
    @(negedge clk);
    checks++; if (lu_ready !== 1'b0) begin errors++; $display("FAIL rst_buf_full: got %b exp 0", lu_ready); end
    adv();
    rst_n = 0; pipe_wren = 0;
    #1;
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL rst_async_ready: got %b exp 1", lu_ready); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_async_err: got %b exp 0", err); end
    checks++; if (rd_wren !== 1'b0) begin errors++; $display("FAIL rst_async_wren: got %b exp 0", rd_wren); end
    adv();
    rst_n = 1;
    rs1_addr = 5'd8; rs2_addr = 5'd9;
    @(negedge clk);
    checks++; if (rd_wren !== 1'b0) begin errors++; $display("FAIL rst_buf_lost: got %b exp 0", rd_wren); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_busy_clear: got %b exp 0", stall); end
    adv();
    @(negedge clk);
    checks++; if (rd_wren !== 1'b0) begin errors++; $display("FAIL rst_no_late_write: got %b exp 0", rd_wren); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_raw_stall();
    test_buffer();
    test_outstanding();
    test_x0();
    test_err_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
